// File: rtl/axi4l_pkg.sv
// AXI4-Lite response codes and state type shared by the memory-side subordinates.
package axi4l_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2
    } imem_state_e;

endpackage

// File: rtl/axi4l_imem_slave.sv
// Read-only AXI4-Lite subordinate serving instruction fetches from a single-port word memory,
// with a one-entry AR slot so the next fetch can be accepted while one is in flight.
module axi4l_imem_slave
    import axi4l_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    PROT_WIDTH  = 3,
    parameter int                    RESP_WIDTH  = 2,
    parameter int                    DATA_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int                    MEM_TIMEOUT = 16,
    localparam int                   IDX_W       = $clog2(DATA_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [PROT_WIDTH-1:0] s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [RESP_WIDTH-1:0] s_axi_rresp,
    output logic                  mem_en,
    output logic [IDX_W-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvld
);

    localparam int                  CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] LIMIT   = (ADDR_WIDTH + 1)'(longint'(DATA_DEPTH) * 4);
    localparam logic [CNT_W-1:0]    TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    imem_state_e           state_q, state_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  pend_err_q, pend_err_d;
    logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
    logic                  arready_q, arready_d;

    logic                  ar_hs;
    logic                  ar_err;
    logic [ADDR_WIDTH-1:0] ar_off;
    logic                  issue;
    logic                  rd_timeout;
    logic                  unused_prot;

    // Offset wraps modulo 2^ADDR_WIDTH, so addresses below the base land far out of range.
    assign ar_off      = s_axi_araddr - BASE_ADDR;
    assign ar_err      = ({1'b0, ar_off} >= LIMIT) || (s_axi_araddr[1:0] != 2'b00);
    assign ar_hs       = s_axi_arvalid && arready_q;
    assign issue       = (state_q == IDLE) && pend_vld_q;
    assign rd_timeout  = (state_q == RD) && !mem_rvld && (cnt_q == TO_LAST);
    assign unused_prot = ^s_axi_arprot;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (pend_vld_q) state_d = pend_err_q ? RSP : RD;
            RD:   if (mem_rvld || rd_timeout) state_d = RSP;
            RSP:  if (s_axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_err_d = pend_err_q;
        pend_idx_d = pend_idx_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        cnt_d      = (state_q == RD) ? cnt_q + 1'b1 : '0;

        if (issue) begin
            pend_vld_d = 1'b0;
            if (pend_err_q) begin
                rdata_d = '0;
                rresp_d = RESP_WIDTH'(RESP_SLVERR);
            end
        end
        // The slot can only be written while empty, so this never collides with issue.
        if (ar_hs) begin
            pend_vld_d = 1'b1;
            pend_err_d = ar_err;
            pend_idx_d = ar_off[IDX_W+1:2];
        end

        if (state_q == RD) begin
            if (mem_rvld) begin
                rdata_d = mem_rdata;
                rresp_d = RESP_WIDTH'(RESP_OKAY);
            end else if (rd_timeout) begin
                rdata_d = '0;
                rresp_d = RESP_WIDTH'(RESP_SLVERR);
            end
        end

        arready_d = !pend_vld_d;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            pend_vld_q <= 1'b0;
            pend_err_q <= 1'b0;
            pend_idx_q <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_WIDTH'(RESP_OKAY);
            arready_q  <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_err_q <= pend_err_d;
            pend_idx_q <= pend_idx_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            arready_q  <= arready_d;
        end
    end

    always_comb begin
        mem_en       = issue && !pend_err_q;
        mem_addr     = mem_en ? pend_idx_q : '0;
        s_axi_rvalid = (state_q == RSP);
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign mem_wdata     = '0;
    assign mem_wen       = 1'b0;

endmodule

// File: tb/tb_axi4l_imem_slave.sv
// Directed plus randomized fetch sequence checked against an address-rule model
// and a latency-programmable memory responder.
module tb_axi4l_imem_slave;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        CLK;
    logic        RSTN;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [31:0] mem_rdata;
    logic        mem_rvld;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_lat  = 1;

    logic [31:0] tb_mem [1024];
    int due_q[$];
    int idx_q[$];

    axi4l_imem_slave dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_araddr (araddr),
        .s_axi_arprot (arprot),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wen      (mem_wen),
        .mem_rdata    (mem_rdata),
        .mem_rvld     (mem_rvld)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    // Memory: a strobe seen in cycle c returns data in cycle c+mem_lat; mem_lat<=0 never answers.
    initial begin
        mem_rvld  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge CLK);
            mem_rvld  = 1'b0;
            mem_rdata = $urandom;
            while (due_q.size() > 0 && due_q[0] < cyc) begin
                void'(due_q.pop_front());
                void'(idx_q.pop_front());
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                mem_rvld  = 1'b1;
                mem_rdata = tb_mem[idx_q[0]];
                void'(due_q.pop_front());
                void'(idx_q.pop_front());
            end
            if (mem_en && mem_lat > 0) begin
                due_q.push_back(cyc + mem_lat);
                idx_q.push_back(int'(mem_addr));
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome from the address rules alone: response, data, and rvalid delay after the AR handshake.
    function automatic void model(input logic [31:0] a, input int lat, output bit legal,
                                  output logic [31:0] d, output logic [1:0] r, output int rel);
        logic [31:0] off;
        off   = a - BASE;
        legal = (off < 32'd4096) && (a % 4 == 0);
        if (!legal) begin
            d = '0; r = 2'b10; rel = 2;
        end else if (lat >= 1 && lat <= 16) begin
            d = tb_mem[off / 4]; r = 2'b00; rel = 2 + lat;
        end else begin
            d = '0; r = 2'b10; rel = 18;
        end
    endfunction

    task automatic wait_rvalid(input int limit);
        int w;
        w = 0;
        while (!rvalid && w < limit) begin
            @(negedge CLK);
            w++;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int lat, input int hold);
        bit          legal;
        logic [31:0] ed;
        logic [1:0]  er;
        logic [31:0] off;
        int          rel, t, w, en_cnt;
        model(a, lat, legal, ed, er, rel);
        off     = a - BASE;
        mem_lat = lat;
        arvalid = 1'b1;
        araddr  = a;
        arprot  = 3'($urandom);
        w = 0;
        while (!arready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        chk("ar_accept", 64'(arready), 64'(1));
        t = cyc;
        @(negedge CLK);
        arvalid = 1'b0;
        en_cnt  = 0;
        w = 0;
        while (!rvalid && w < 40) begin
            if (mem_en) begin
                en_cnt++;
                chk("mem_en_cycle", 64'(cyc), 64'(t + 1));
                chk("mem_addr", 64'(mem_addr), 64'(off[11:2]));
            end
            @(negedge CLK);
            w++;
        end
        chk("rvalid_cycle", 64'(cyc), 64'(t + rel));
        chk("mem_en_count", 64'(en_cnt), legal ? 64'(1) : 64'(0));
        chk("rdata", 64'(rdata), 64'(ed));
        chk("rresp", 64'(rresp), 64'(er));
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("rdata_hold", 64'(rdata), 64'(ed));
            chk("rvalid_hold", 64'(rvalid), 64'(1));
        end
        rready = 1'b1;
        @(negedge CLK);
        rready = 1'b0;
        chk("rvalid_drop", 64'(rvalid), 64'(0));
        $display("txn addr=%h lat=%0d rdata=%h rresp=%b cycles=%0d", a, lat, rdata, rresp, rel);
    endtask

    initial begin
        logic [31:0] a1, a2, d1, d2, ra;
        logic [1:0]  r1, r2;
        bit          l1, l2;
        int          rel1, rel2, t1, ti;

        for (int i = 0; i < 1024; i++) tb_mem[i] = $urandom;
        tb_mem[0] = 32'h0000_0013;

        RSTN    = 1'b0;
        arvalid = 1'b0;
        araddr  = '0;
        arprot  = '0;
        rready  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_rresp", 64'(rresp), 64'(0));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("mem_wen", 64'(mem_wen), 64'(0));
        chk("mem_wdata", 64'(mem_wdata), 64'(0));
        RSTN = 1'b1;
        @(negedge CLK);
        chk("arready_after_rst", 64'(arready), 64'(1));

        // Directed address cases.
        do_read(32'hFFFF_0000, 1, 0);
        do_read(32'hFFFF_0FFC, 2, 1);
        do_read(32'hFFFF_1000, 1, 0);
        do_read(32'hFFFF_0002, 1, 0);
        do_read(32'h0000_0000, 1, 0);

        // Randomized fetches.
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    ra = BASE + 32'($urandom_range(0, 1023)) * 4;
                2:       ra = BASE + 32'($urandom_range(0, 4095)) | 32'h1;
                default: ra = $urandom;
            endcase
            do_read(ra, $urandom_range(1, 4), $urandom_range(0, 3));
        end

        // Second AR accepted while the first is in flight; responses in order.
        a1 = BASE + 32'd20;
        a2 = BASE + 32'd4092;
        model(a1, 2, l1, d1, r1, rel1);
        model(a2, 2, l2, d2, r2, rel2);
        mem_lat = 2;
        arvalid = 1'b1;
        araddr  = a1;
        t1 = cyc;
        @(negedge CLK);
        arvalid = 1'b0;
        chk("slot_full_arready", 64'(arready), 64'(0));
        chk("ovl_mem_en1", 64'(mem_en), 64'(1));
        chk("ovl_mem_addr1", 64'(mem_addr), 64'(5));
        @(negedge CLK);
        chk("slot_free_arready", 64'(arready), 64'(1));
        arvalid = 1'b1;
        araddr  = a2;
        @(negedge CLK);
        arvalid = 1'b0;
        chk("slot_refill_arready", 64'(arready), 64'(0));
        wait_rvalid(30);
        chk("ovl_rvalid1_cycle", 64'(cyc), 64'(t1 + rel1));
        for (int i = 0; i < 5; i++) begin
            chk("ovl_rdata1_stable", 64'(rdata), 64'(d1));
            chk("ovl_rresp1", 64'(rresp), 64'(r1));
            chk("ovl_arready_held", 64'(arready), 64'(0));
            @(negedge CLK);
        end
        rready = 1'b1;
        @(negedge CLK);
        rready = 1'b0;
        chk("ovl_rvalid_drop", 64'(rvalid), 64'(0));
        chk("ovl_mem_en2", 64'(mem_en), 64'(1));
        chk("ovl_mem_addr2", 64'(mem_addr), 64'(1023));
        ti = cyc;
        wait_rvalid(30);
        chk("ovl_rvalid2_cycle", 64'(cyc), 64'(ti + 1 + 2));
        chk("ovl_rdata2", 64'(rdata), 64'(d2));
        chk("ovl_rresp2", 64'(rresp), 64'(r2));
        $display("txn overlap first=%h second=%h rdata2=%h", d1, d2, rdata);
        rready = 1'b1;
        @(negedge CLK);
        rready = 1'b0;

        // Memory never answers, then answers too late.
        do_read(BASE + 32'd64, 0, 0);
        do_read(BASE + 32'd128, 20, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("stray_rvld_ignored", 64'(rvalid), 64'(0));
        end
        do_read(BASE + 32'd256, 16, 0);

        // Reset while a response is waiting.
        mem_lat = 1;
        arvalid = 1'b1;
        araddr  = BASE + 32'd8;
        @(negedge CLK);
        arvalid = 1'b0;
        wait_rvalid(30);
        chk("pre_rst_rvalid", 64'(rvalid), 64'(1));
        RSTN = 1'b0;
        @(negedge CLK);
        chk("rst_rsp_rvalid", 64'(rvalid), 64'(0));
        chk("rst_rsp_arready", 64'(arready), 64'(0));
        chk("rst_rsp_rdata", 64'(rdata), 64'(0));
        chk("rst_rsp_rresp", 64'(rresp), 64'(0));
        RSTN = 1'b1;
        @(negedge CLK);
        chk("rst_rsp_arready_back", 64'(arready), 64'(1));
        $display("txn reset_in_rsp rvalid=%b arready=%b", rvalid, arready);

        // Reset while the memory read is in flight; its late data must not surface.
        mem_lat = 3;
        arvalid = 1'b1;
        araddr  = BASE + 32'd12;
        @(negedge CLK);
        arvalid = 1'b0;
        @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        chk("rst_rd_arready_back", 64'(arready), 64'(1));
        for (int i = 0; i < 5; i++) begin
            chk("rst_rd_no_rvalid", 64'(rvalid), 64'(0));
            @(negedge CLK);
        end
        $display("txn reset_in_rd rvalid=%b", rvalid);
        do_read(BASE + 32'd12, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
